bullet_pool: RTL

Parametrised player-bullet manager for the Space Invaders datapath. It holds N independent bullet slots and launches a bullet from the player plane into the lowest free slot. It advances all live bullets upward on each movement tick and retires them at the screen top or on a collision hit. It sits between the keyboard decoder and the per-sprite address generators, which consume its packed positions and active flags.

---
 rtl/bullet_pkg.sv | 28 ++
 rtl/bullet_slot.sv | 60 ++++++
 rtl/bullet_pool.sv | 108 ++++++++++
 3 files changed

// File: rtl/bullet_pkg.sv
// Shared defaults and the free-slot search used by the bullet pool.
package bullet_pkg;

  localparam int COORD_W_DEF  = 10;
  localparam int STEP_DEF     = 4;
  localparam int SPRITE_H_DEF = 16;
  localparam int MAX_SLOTS    = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } free_t;

  // Unused upper slots must be passed in as 1 so they never look free.
  function automatic free_t lowest_free(input logic [MAX_SLOTS-1:0] act);
    free_t r;
    r.valid = 1'b0;
    r.idx   = 4'd0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (!act[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet: live flag plus position, with launch, upward move and hit retire.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int TOP_LIMIT = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               launch_i,
  input  logic               move_i,
  input  logic               hit_i,
  input  logic [COORD_W-1:0] h_load_i,
  input  logic [COORD_W-1:0] v_load_i,
  output logic               active_o,
  output logic [COORD_W-1:0] h_o,
  output logic [COORD_W-1:0] v_o
);

  localparam logic [COORD_W:0]   RETIRE_BELOW = (COORD_W+1)'(TOP_LIMIT + STEP);
  localparam logic [COORD_W-1:0] STEP_V       = COORD_W'(STEP);

  logic               active_q, active_d;
  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;

  // Hit wins over movement; launch only ever targets an idle slot.
  always_comb begin
    active_d = active_q;
    h_d      = h_q;
    v_d      = v_q;
    if (hit_i && active_q) begin
      active_d = 1'b0;
    end else if (launch_i) begin
      active_d = 1'b1;
      h_d      = h_load_i;
      v_d      = v_load_i;
    end else if (move_i && active_q) begin
      if ({1'b0, v_q} < RETIRE_BELOW) active_d = 1'b0;
      else                            v_d      = v_q - STEP_V;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      active_q <= active_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  assign active_o = active_q;
  assign h_o      = h_q;
  assign v_o      = v_q;

endmodule

// File: rtl/bullet_pool.sv
// Player bullet manager: fire request, launch cooldown, lowest-free allocation
// and packing of the per-slot positions.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int N_BULLETS = 5,
  parameter int COORD_W   = COORD_W_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int TOP_LIMIT = 0,
  parameter int SPRITE_H  = SPRITE_H_DEF,
  parameter int H_OFS     = 8,
  parameter int COOLDOWN  = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           tick_i,
  input  logic                           fire_i,
  input  logic                           auto_mode_i,
  input  logic [COORD_W-1:0]             h_plane_i,
  input  logic [COORD_W-1:0]             v_plane_i,
  input  logic [N_BULLETS-1:0]           hit_i,
  output logic [N_BULLETS-1:0]           active_o,
  output logic [N_BULLETS*COORD_W-1:0]   h_bullet_o,
  output logic [N_BULLETS*COORD_W-1:0]   v_bullet_o,
  output logic                           fire_ack_o,
  output logic                           pool_full_o
);

  localparam int                 CD_W      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0]    CD_LOAD   = CD_W'(COOLDOWN);
  localparam logic [COORD_W:0]   SPAWN_MIN = (COORD_W+1)'(TOP_LIMIT + SPRITE_H);

  logic                 fire_q, armed_q, pend_q, pend_d;
  logic                 fire_ack_q, pool_full_q;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 edge_fire, pend_eff, launch;
  logic [MAX_SLOTS-1:0] act_pad;
  free_t                free;
  logic [COORD_W-1:0]   h_spawn, v_spawn;
  logic [N_BULLETS-1:0] active;

  // armed_q blocks a press that was already held through reset from
  // counting as a new edge; the key must be released first.
  assign edge_fire = fire_i & ~fire_q & armed_q;
  assign pend_eff  = auto_mode_i ? fire_i : (pend_q | edge_fire);
  assign pend_d    = tick_i ? 1'b0 : (pend_q | edge_fire);

  always_comb begin
    act_pad                = '1;
    act_pad[N_BULLETS-1:0] = active;
    free                   = lowest_free(act_pad);
  end

  assign launch  = tick_i & pend_eff & (cd_q == '0) & free.valid;
  assign h_spawn = h_plane_i + COORD_W'(H_OFS);
  assign v_spawn = ({1'b0, v_plane_i} < SPAWN_MIN) ? COORD_W'(TOP_LIMIT)
                                                   : v_plane_i - COORD_W'(SPRITE_H);

  always_comb begin
    cd_d = cd_q;
    if (tick_i) begin
      if (launch)           cd_d = CD_LOAD;
      else if (cd_q != '0)  cd_d = cd_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fire_q      <= 1'b0;
      armed_q     <= ~fire_i;
      pend_q      <= 1'b0;
      cd_q        <= '0;
      fire_ack_q  <= 1'b0;
      pool_full_q <= 1'b0;
    end else begin
      fire_q      <= fire_i;
      armed_q     <= armed_q | ~fire_i;
      pend_q      <= pend_d;
      cd_q        <= cd_d;
      fire_ack_q  <= launch;
      pool_full_q <= &active;
    end
  end

  for (genvar i = 0; i < N_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .COORD_W  (COORD_W),
      .STEP     (STEP),
      .TOP_LIMIT(TOP_LIMIT)
    ) u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .launch_i (launch && (free.idx == 4'(i))),
      .move_i   (tick_i),
      .hit_i    (hit_i[i]),
      .h_load_i (h_spawn),
      .v_load_i (v_spawn),
      .active_o (active[i]),
      .h_o      (h_bullet_o[i*COORD_W +: COORD_W]),
      .v_o      (v_bullet_o[i*COORD_W +: COORD_W])
    );
  end

  assign active_o    = active;
  assign fire_ack_o  = fire_ack_q;
  assign pool_full_o = pool_full_q;

endmodule
